// File: rtl/prefetch_meta_tracker.sv
// Per-bank line metadata {prefetched, used, use_cnt} with a two-stage read-modify-write and an init sweep.
// Optional prefetch accuracy counters are built when PF_TRACKER_PERF_EN is defined.
module prefetch_meta_tracker #(
  parameter int CACHE_ID        = 0,
  parameter int BANK_ID         = 0,
  parameter int CACHE_SIZE      = 16384,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int NUM_BANKS       = 4,
  parameter int USE_CNT_BITS    = 2,
  parameter int PERF_CTR_WIDTH  = 32,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       req_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] req_addr,
  input  logic                       req_fill,
  input  logic                       req_fill_pf,
  input  logic                       req_prefetch,
  output logic                       ready,
  output logic                       rsp_valid,
  output logic                       rsp_prefetched,
  output logic                       rsp_used,
  output logic [USE_CNT_BITS-1:0]    rsp_use_cnt,
  input  logic                       perf_clear,
  output logic [PERF_CTR_WIDTH-1:0]  perf_useful,
  output logic [PERF_CTR_WIDTH-1:0]  perf_useless,
  output logic                       dbg_state
);

  localparam int LINES = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
  localparam int LSEL  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int EW    = 2 + USE_CNT_BITS;
  localparam logic [LSEL-1:0] LAST_IDX = LSEL'(LINES - 1);
  localparam int unused_ids = CACHE_ID + BANK_ID;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [LSEL-1:0]   sweep_q, sweep_d;
  logic              ready_q, ready_d;
  logic              s2_valid_q, s2_valid_d;
  logic [LSEL-1:0]   s2_idx_q, s2_idx_d;
  logic [EW-1:0]     s2_old_q, s2_old_d;
  logic              s2_fill_q, s2_fill_d;
  logic              s2_fill_pf_q, s2_fill_pf_d;
  logic              s2_probe_q, s2_probe_d;
  logic [EW-1:0]     mem_q [LINES];

  logic              accept;
  logic              wb_en;
  logic [EW-1:0]     wb_new;
  logic [LSEL-1:0]   req_idx;
  logic [EW-1:0]     rd_data;
  logic              old_pf, old_used;
  logic [USE_CNT_BITS-1:0] old_cnt;
  logic              unused_bits;

  assign unused_bits = ^{req_addr, perf_clear};

  // A request transfers when req_valid && ready && !stall; the response is valid the next
  // cycle and holds (stall stretches it) until the writeback cycle completes.
  assign req_idx  = req_addr[LSEL-1:0];
  assign accept   = req_valid && ready_q && !stall;
  assign old_pf   = s2_old_q[EW-1];
  assign old_used = s2_old_q[EW-2];
  assign old_cnt  = s2_old_q[USE_CNT_BITS-1:0];
  assign wb_en    = s2_valid_q && !stall && !s2_probe_q;

  always_comb begin
    wb_new = '0;
    if (s2_fill_q) begin
      wb_new = {s2_fill_pf_q, 1'b1 ^ 1'b1, {USE_CNT_BITS{1'b0}}};
    end else begin
      wb_new = {old_pf, 1'b1, (old_cnt == '1) ? old_cnt : old_cnt + USE_CNT_BITS'(1)};
    end
  end

  // Forward the in-flight writeback so back-to-back same-line requests see cumulative updates.
  assign rd_data = (wb_en && (s2_idx_q == req_idx)) ? wb_new : mem_q[req_idx];

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    s2_valid_d   = s2_valid_q;
    s2_idx_d     = s2_idx_q;
    s2_old_d     = s2_old_q;
    s2_fill_d    = s2_fill_q;
    s2_fill_pf_d = s2_fill_pf_q;
    s2_probe_d   = s2_probe_q;
    case (state_q)
      S_INIT: begin
        sweep_d    = sweep_q + LSEL'(1);
        s2_valid_d = 1'b0;
        if (sweep_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (!stall) begin
          s2_valid_d = accept;
          if (accept) begin
            s2_idx_d     = req_idx;
            s2_old_d     = rd_data;
            s2_fill_d    = req_fill;
            s2_fill_pf_d = req_fill_pf;
            s2_probe_d   = req_prefetch && !req_fill;
          end
        end
      end
    endcase
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      ready_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_idx_q     <= '0;
      s2_old_q     <= '0;
      s2_fill_q    <= 1'b0;
      s2_fill_pf_q <= 1'b0;
      s2_probe_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ready_q      <= ready_d;
      s2_valid_q   <= s2_valid_d;
      s2_idx_q     <= s2_idx_d;
      s2_old_q     <= s2_old_d;
      s2_fill_q    <= s2_fill_d;
      s2_fill_pf_q <= s2_fill_pf_d;
      s2_probe_q   <= s2_probe_d;
    end
  end

  // Storage has no reset; the init sweep zeroes every line before RUN.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[sweep_q] <= '0;
    end else if (wb_en) begin
      mem_q[s2_idx_q] <= wb_new;
    end
  end

  assign ready          = ready_q;
  assign rsp_valid      = s2_valid_q;
  assign rsp_prefetched = old_pf;
  assign rsp_used       = old_used;
  assign rsp_use_cnt    = old_cnt;
  assign dbg_state      = state_q;

`ifdef PF_TRACKER_PERF_EN
  logic [PERF_CTR_WIDTH-1:0] useful_q, useful_d;
  logic [PERF_CTR_WIDTH-1:0] useless_q, useless_d;
  logic                      pf_unused_line;

  assign pf_unused_line = old_pf && !old_used;

  always_comb begin
    useful_d  = useful_q;
    useless_d = useless_q;
    if (perf_clear) begin
      useful_d  = '0;
      useless_d = '0;
    end else if (wb_en && pf_unused_line) begin
      if (s2_fill_q && (useless_q != '1)) begin
        useless_d = useless_q + PERF_CTR_WIDTH'(1);
      end
      if (!s2_fill_q && (useful_q != '1)) begin
        useful_d = useful_q + PERF_CTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      useful_q  <= '0;
      useless_q <= '0;
    end else begin
      useful_q  <= useful_d;
      useless_q <= useless_d;
    end
  end

  assign perf_useful  = useful_q;
  assign perf_useless = useless_q;
`else
  assign perf_useful  = '0;
  assign perf_useless = '0;
`endif

endmodule

// File: tb/tb_prefetch_meta_tracker.sv
// Bench for prefetch_meta_tracker: vector table through a response scoreboard, plus stall,
// mid-run reset and perf_clear sequences.
module tb_prefetch_meta_tracker;

  localparam int AW    = 26;
  localparam int CW    = 2;
  localparam int PW    = 32;
  localparam int LINES = 64;
`ifdef PF_TRACKER_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_fill = 1'b0;
  logic          req_fill_pf = 1'b0;
  logic          req_prefetch = 1'b0;
  logic          perf_clear = 1'b0;
  logic          ready, rsp_valid, rsp_prefetched, rsp_used, dbg_state;
  logic [CW-1:0] rsp_use_cnt;
  logic [PW-1:0] perf_useful, perf_useless;

  typedef struct {
    logic       fill;
    logic       fill_pf;
    logic       prefetch;
    logic [5:0] line;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs [16];
  logic [3:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  prefetch_meta_tracker #(.USE_CNT_BITS(CW), .PERF_CTR_WIDTH(PW), .LINE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid), .req_addr(req_addr),
    .req_fill(req_fill), .req_fill_pf(req_fill_pf), .req_prefetch(req_prefetch),
    .ready(ready), .rsp_valid(rsp_valid), .rsp_prefetched(rsp_prefetched),
    .rsp_used(rsp_used), .rsp_use_cnt(rsp_use_cnt), .perf_clear(perf_clear),
    .perf_useful(perf_useful), .perf_useless(perf_useless), .dbg_state(dbg_state)
  );

  function automatic logic [3:0] rsp_word();
    return {rsp_prefetched, rsp_used, rsp_use_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic fill, input logic pf, input logic probe, input logic [5:0] line);
    req_valid    = 1'b1;
    req_fill     = fill;
    req_fill_pf  = pf;
    req_prefetch = probe;
    req_addr     = {{(AW-6){1'b0}}, line};
  endtask

  task automatic idle();
    req_valid    = 1'b0;
    req_fill     = 1'b0;
    req_fill_pf  = 1'b0;
    req_prefetch = 1'b0;
  endtask

  task automatic pop_check(input string name);
    check({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: response %0h with no expected entry queued", name, rsp_word());
    end else begin
      check(name, {28'b0, rsp_word()}, {28'b0, exp_q.pop_front()});
    end
  endtask

  task automatic send(input logic fill, input logic pf, input logic probe, input logic [5:0] line,
                      input logic [3:0] exp, input string name);
    drive_req(fill, pf, probe, line);
    exp_q.push_back(exp);
    tick();
    pop_check(name);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    check({name, "_ready_low"}, {31'b0, ready}, 32'd0);
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    check({name, "_init_cycles"}, n, LINES);
    check({name, "_dbg_run"}, {31'b0, dbg_state}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'd5, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'd3, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 6'd3, 4'b1000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 6'd3, 4'b1101};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 6'd7, 4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 6'd7, 4'b1000};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'd7, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'd9, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 6'd9, 4'b0101};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'd9, 4'b0110};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 6'd9, 4'b0111};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 6'd9, 4'b0111};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 6'd5, 4'b0101};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 6'd5, 4'b0101};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 6'd5, 4'b0110};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 6'd5, 4'b1000};

    // Reset state.
    repeat (3) tick();
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_word", {28'b0, rsp_word()}, 32'd0);
    check("reset_perf_useful", perf_useful, 32'd0);
    check("reset_perf_useless", perf_useless, 32'd0);
    check("reset_dbg_init", {31'b0, dbg_state}, 32'd0);
    reset = 1'b1;
    wait_ready("boot");

    // Back-to-back table, exercising forwarding and saturation.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].fill, vecs[i].fill_pf, vecs[i].prefetch, vecs[i].line, vecs[i].exp,
           $sformatf("vec%0d", i));
    end
    idle();
    tick();
    check("table_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("table_perf_useful", perf_useful, PERF_ON ? 32'd2 : 32'd0);
    check("table_perf_useless", perf_useless, PERF_ON ? 32'd1 : 32'd0);

    // Stall with a response pending and a demand waiting behind it.
    send(1'b0, 1'b0, 1'b0, 6'd11, 4'b0000, "stall_first");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_hold_valid%0d", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("stall_hold_word%0d", i), {28'b0, rsp_word()}, 32'd0);
    end
    exp_q.push_back(4'b0101);
    stall = 1'b0;
    tick();
    pop_check("stall_release");
    send(1'b0, 1'b0, 1'b1, 6'd11, 4'b0110, "stall_probe11");
    send(1'b0, 1'b0, 1'b1, 6'd9, 4'b0111, "probe9_a");
    send(1'b0, 1'b0, 1'b1, 6'd9, 4'b0111, "probe9_b");
    idle();
    tick();

    // Reset with a request in flight.
    send(1'b0, 1'b0, 1'b0, 6'd3, 4'b1110, "pre_reset");
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midreset_ready", {31'b0, ready}, 32'd0);
    check("midreset_dbg_init", {31'b0, dbg_state}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    wait_ready("rerun");
    check("rerun_perf_useful", perf_useful, 32'd0);
    check("rerun_perf_useless", perf_useless, 32'd0);
    for (int i = 0; i < LINES; i++) begin
      send(1'b0, 1'b0, 1'b1, 6'(i), 4'b0000, $sformatf("zero_line%0d", i));
    end
    idle();
    tick();

    // perf_clear against a simultaneous useful event, then a plain useful event.
    send(1'b1, 1'b1, 1'b0, 6'd3, 4'b0000, "clr_fill");
    send(1'b0, 1'b0, 1'b0, 6'd3, 4'b1000, "clr_demand");
    idle();
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    check("clear_wins", perf_useful, 32'd0);
    send(1'b1, 1'b1, 1'b0, 6'd4, 4'b0000, "use_fill");
    send(1'b0, 1'b0, 1'b0, 6'd4, 4'b1000, "use_demand");
    idle();
    tick();
    check("useful_after_clear", perf_useful, PERF_ON ? 32'd1 : 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_meta_tracker.md
Name: prefetch_meta_tracker

Overview:
- Per-bank line-metadata store: prefetched bit, used bit, saturating demand-use counter per cache line.
- Successor to the single-bit used store. Adds a use-count field of parameterised width, prefetch-origin tracking, a pipelined read-modify-write with forwarding, and a hardware init sweep.
- Optional useful/useless prefetch counters.
- Sits beside the tag/data stores in each cache bank; fed by the bank pipeline's fill/access stage.

Parameters:
- CACHE_ID, 0, cache instance id (trace only)
- BANK_ID, 0, bank id (trace only)
- CACHE_SIZE, 16384, cache bytes
- CACHE_LINE_SIZE, 64, line bytes
- NUM_BANKS, 4, bank count
- USE_CNT_BITS, 2, width of per-line saturating use counter (>=1)
- PERF_CTR_WIDTH, 32, width of prefetch accuracy counters
- Derived: LINES = CACHE_SIZE/(CACHE_LINE_SIZE*NUM_BANKS); LSEL = clog2(LINES). Indexing uses addr[LSEL-1:0].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  freezes pipeline
- req_valid  in  1  request present
- req_addr  in  LINE_ADDR_WIDTH  line address
- req_fill  in  1  line fill
- req_fill_pf  in  1  fill originated from prefetcher
- req_prefetch  in  1  prefetch probe (no metadata update)
- ready  out  1  tracker can accept
- rsp_valid  out  1  metadata response valid
- rsp_prefetched  out  1  pre-update prefetched bit
- rsp_used  out  1  pre-update used bit
- rsp_use_cnt  out  USE_CNT_BITS  pre-update use count
- perf_clear  in  1  zero perf counters (feature only)
- perf_useful  out  PERF_CTR_WIDTH  prefetched lines later demand-used (feature only)
- perf_useless  out  PERF_CTR_WIDTH  prefetched lines evicted unused (feature only)

Behaviour:
- Entry format: {prefetched, used, use_cnt}.
- Reset (reset=0, async):
  - FSM to INIT; sweep index to 0.
  - ready=0, rsp_valid=0, all rsp_* outputs 0.
  - Perf counters 0.
- FSM:
  - INIT: writes zero entry at sweep index each cycle, ignores stall; after index LINES-1 goes to RUN. Duration is exactly LINES cycles after reset release.
  - RUN: ready=1.
  - Reset asserted mid-RUN returns to INIT and discards any in-flight request.
- Accept: req_valid && ready && !stall in cycle T.
  - Stage1 at T registers the read.
  - Cycle T+1: rsp_valid=1 and rsp_* carry the old entry. The updated entry is written back in T+1 if !stall.
  - rsp_valid deasserts the cycle after the writeback unless a new request was accepted.
- Stall=1 with stage2 occupied: rsp_* held stable, writeback deferred, no accept.
- Update rules (exactly one applies; req_fill has priority over req_prefetch):
  - fill: new = {req_fill_pf, 0, 0}. Old prefetched=1 && used=0 -> useless+1.
  - demand access (!fill && !prefetch): used=1, use_cnt saturating +1 (holds at 2^USE_CNT_BITS-1), prefetched unchanged. Old prefetched=1 && used=0 -> useful+1.
  - prefetch probe: no write; response still returned.
- Hazard: a new accept to the index being written back in the same cycle captures the written (new) value, not the RAM value. Back-to-back same-line requests therefore see cumulative updates.
- Perf counters:
  - Saturate at all-ones.
  - perf_clear is synchronous; it wins over a simultaneous increment.

Optional Feature:
- Macro PF_TRACKER_PERF_EN.
- Defined: perf_useful/perf_useless counters and perf_clear are implemented as above.
- Undefined: counters are not instantiated; perf_useful/perf_useless are tied to 0; perf_clear is unused. Metadata behaviour is otherwise identical.

Test Plan:
- Init: release reset with LINES=64 -> ready=0 for 64 cycles, then 1. A demand to line 5 then returns rsp_prefetched=0, rsp_used=0, rsp_use_cnt=0.
- Useful prefetch: fill line 3 with req_fill_pf=1, then demand line 3 -> rsp {1,0,0}, perf_useful=1. A second demand returns {1,1,1}; perf_useful stays 1.
- Useless eviction: fill line 7 with req_fill_pf=1, then fill line 7 with req_fill_pf=0 -> perf_useless=1. The next demand returns {0,0,0}.
- Saturation/forwarding (USE_CNT_BITS=2): five back-to-back demands to line 9 -> rsp_use_cnt 0,1,2,3,3. No stale read on consecutive cycles.
- Stall: assert stall 3 cycles with response pending -> rsp_* stable, ready-accept blocked, writeback once after release. A prefetch probe to line 9 returns {0,1,3} and leaves the entry unchanged.
- Reset mid-RUN with request in flight -> rsp_valid=0 immediately, INIT sweep reruns, all lines read zero afterward. perf_clear together with a useful event -> counter reads 0.
